pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; legal values are multiples of SLICE, from SLICE to 64.
REQ-002 SHALL provide parameter SLICE, default 16, bits added per pipeline stage; legal values are 4, 8 or 16.
REQ-003 SHALL provide port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: operand bundle valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: block accepts bundle this cycle.
REQ-007 SHALL provide port in1, input, WIDTH bits: operand A.
REQ-008 SHALL provide port in2, input, WIDTH bits: operand B.
REQ-009 SHALL provide port sub, input, 1 bit: 0 selects A+B+c_in, 1 selects A-B.
REQ-010 SHALL provide port c_in, input, 1 bit: carry-in, used only when sub=0.
REQ-011 SHALL provide port out_valid, output, 1 bit: result valid.
REQ-012 SHALL provide port out_ready, input, 1 bit: consumer accepts result.
REQ-013 SHALL provide port sum, output, WIDTH bits: result.
REQ-014 SHALL provide port c_out, output, 1 bit: carry out of MSB.
REQ-015 SHALL provide port ovf, output, 1 bit: signed overflow.
REQ-016 SHALL provide port zero, output, 1 bit: sum equals 0.

Function
REQ-017 SHALL split operands into N=WIDTH/SLICE slices; stage k (0..N-1) SHALL add slice k with the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-018 Each slice adder SHALL be a 4-bit-group carry-lookahead adder with lookahead carry unit (group P/G), with no ripple between 4-bit groups.
REQ-019 For sub=1, B SHALL be bitwise inverted and the effective carry-in SHALL be 1; c_in is ignored; c_out=1 means no borrow.
REQ-020 Not-yet-added upper operand slices SHALL be carried forward unchanged, and completed lower sum slices SHALL be delayed, so all result bits leave the final stage together.
REQ-021 Pipeline SHALL advance when stall=0, where stall = out_valid AND NOT out_ready; stall SHALL freeze every stage register, including all valid bits.
REQ-022 in_ready SHALL equal NOT stall; a transfer occurs on a rising edge where in_valid AND in_ready.
REQ-023 Latency SHALL be exactly N cycles from input transfer to out_valid=1 with no stall; throughput SHALL be one result per cycle.
REQ-024 Results SHALL emerge in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-025 Simultaneous output acceptance and input transfer in one cycle SHALL both take effect.
REQ-026 sum, c_out, ovf and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 ovf SHALL be 1 iff A and the effective B have equal MSBs and sum MSB differs from them.
REQ-028 Bubbles (stage valid=0) SHALL propagate without affecting neighbouring valid entries.

Reset
REQ-029 On rst=1 at a clock edge, all stage valid bits, out_valid, sum, c_out, ovf and zero SHALL become 0, discarding in-flight operations.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-031 A transfer presented in the same cycle as rst=1 SHALL be dropped.

Configuration
REQ-032 With macro PIPE_CLA_FLAGS_EN defined, ovf and zero SHALL be computed per REQ-016 and REQ-027 and registered alongside sum.
REQ-033 Without PIPE_CLA_FLAGS_EN, ovf and zero SHALL be constant 0 with no flag logic; sum, c_out and timing SHALL be unchanged.

Verification (WIDTH=32, SLICE=16, PIPE_CLA_FLAGS_EN defined)
REQ-034 Bench SHALL drive 0xFFFFFFFF + 0x00000001, sub=0, c_in=0 -> after 2 cycles sum=0x00000000, c_out=1, zero=1, ovf=0.
REQ-035 Bench SHALL drive 5 - 7 (sub=1) -> sum=0xFFFFFFFE, c_out=0, ovf=0, zero=0.
REQ-036 Bench SHALL drive 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, c_out=0.
REQ-037 Bench SHALL send 4 back-to-back bundles with out_ready low for cycles 3-5 -> in_ready=0 during the stall, all 4 results in order, each held stable while stalled.
REQ-038 Bench SHALL assert rst for 1 cycle with 2 operations in flight -> next cycle out_valid=0 and in_ready=1, and no stale result ever appears.
REQ-039 Bench SHALL rebuild with WIDTH=64, SLICE=8, macro undefined, and drive 0x00000000FFFFFFFF + 1 -> after 8 cycles sum=0x0000000100000000, ovf=0, zero=0.

Source files
------------

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: slice-pipelined CLA adder/subtractor; ovf/zero flags built only with PIPE_CLA_FLAGS_EN
module pipe_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int NG = SLICE / 4;

    function automatic logic [SLICE:0] cla(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y, input logic ci);
        logic [SLICE-1:0] g, p, c;
        logic [NG-1:0] gg, pg;
        logic [NG:0] cg;
        logic t;
        g = x & y;
        p = x ^ y;
        c = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | ((&p[4*j+2 +: 2]) & g[4*j+1]) | ((&p[4*j+1 +: 3]) & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        // every carry is a flat sum of products, so no carry ripples through a group
        for (int j = 0; j <= NG; j++) begin
            t = ci;
            for (int m = 0; m < j; m++) t &= pg[m];
            cg[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t &= pg[m];
                cg[j] |= t;
            end
        end
        for (int j = 0; j < NG; j++)
            for (int b = 0; b < 4; b++) begin
                t = cg[j];
                for (int m = 0; m < b; m++) t &= p[4*j+m];
                c[4*j+b] = t;
                for (int i = 0; i < b; i++) begin
                    t = g[4*j+i];
                    for (int m = i + 1; m < b; m++) t &= p[4*j+m];
                    c[4*j+b] |= t;
                end
            end
        return {cg[NG], p ^ c};
    endfunction

    logic             v_r [N];
    logic             c_r [N];
    logic [WIDTH-1:0] a_r [N];
    logic [WIDTH-1:0] b_r [N];
    logic [WIDTH-1:0] s_r [N];
    logic             nv  [N];
    logic             nc  [N];
    logic [WIDTH-1:0] na  [N];
    logic [WIDTH-1:0] nb  [N];
    logic [WIDTH-1:0] ns  [N];
    logic             stall;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_r[N-1];
    assign sum       = s_r[N-1];
    assign c_out     = c_r[N-1];

    // b is stored already inverted for subtraction; upper slices ride along untouched
    always_comb begin
        logic [WIDTH-1:0] ca, cb, cs;
        logic cc, cv;
        logic [SLICE:0] r;
        ca = in1;
        cb = sub ? ~in2 : in2;
        cs = '0;
        cc = sub | c_in;
        cv = in_valid & in_ready;
        for (int k = 0; k < N; k++) begin
            r = cla(ca[k*SLICE +: SLICE], cb[k*SLICE +: SLICE], cc);
            nv[k] = cv;
            na[k] = ca;
            nb[k] = cb;
            nc[k] = r[SLICE];
            ns[k] = cs;
            ns[k][k*SLICE +: SLICE] = r[SLICE-1:0];
            ca = a_r[k];
            cb = b_r[k];
            cs = s_r[k];
            cc = c_r[k];
            cv = v_r[k];
        end
    end

    always_ff @(posedge clk)
        if (rst)
            for (int k = 0; k < N; k++) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        else if (!stall)
            for (int k = 0; k < N; k++) begin
                v_r[k] <= nv[k];
                c_r[k] <= nc[k];
                a_r[k] <= na[k];
                b_r[k] <= nb[k];
                s_r[k] <= ns[k];
            end

`ifdef PIPE_CLA_FLAGS_EN
    always_ff @(posedge clk)
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (!stall) begin
            ovf  <= (na[N-1][WIDTH-1] == nb[N-1][WIDTH-1]) && (ns[N-1][WIDTH-1] != na[N-1][WIDTH-1]);
            zero <= ~|ns[N-1];
        end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// tb_pipe_cla_addsub: scoreboard bench for pipe_cla_addsub (32/16 main DUT, 64/8 second DUT)
module tb_pipe_cla_addsub;
`ifdef PIPE_CLA_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk, rst, in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, ovf, zero;
    logic [31:0] in1, in2, sum;
    logic        x_in_valid, x_in_ready, x_out_valid, x_c_out, x_ovf, x_zero;
    logic [63:0] x_in1, x_in2, x_sum;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   popped = 0;
    bit   last_acc;

    pipe_cla_addsub #(.WIDTH(32), .SLICE(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .sub(sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    pipe_cla_addsub #(.WIDTH(64), .SLICE(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .in1(x_in1), .in2(x_in2),
        .sub(1'b0), .c_in(1'b0), .out_valid(x_out_valid), .out_ready(1'b1), .sum(x_sum),
        .c_out(x_c_out), .ovf(x_ovf), .zero(x_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sb, input logic ci);
        logic [31:0] be;
        logic [32:0] t;
        exp_t e;
        be = sb ? ~b : b;
        t = {1'b0, a} + {1'b0, be} + 33'(sb | ci);
        e.s = t[31:0];
        e.c = t[32];
        e.o = FL && (a[31] == be[31]) && (t[31] != a[31]);
        e.z = FL && (t[31:0] == 32'd0);
        return e;
    endfunction

    // one clock: note handshakes before the edge, update the scoreboard, compare after it
    task automatic step();
        bit ai, ao;
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b0) chk("stall_in_ready", in_ready, 0);
        ai = in_valid && in_ready && !rst;
        ao = out_valid && out_ready && !rst;
        @(posedge clk);
        last_acc = ai;
        if (rst) q.delete();
        else begin
            if (ao && q.size() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (ai) q.push_back(model(in1, in2, sub, c_in));
        end
        #1;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) chk("stale_out", out_valid, 0);
            else begin
                chk("sum", sum, q[0].s);
                chk("c_out", c_out, q[0].c);
                chk("ovf", ovf, q[0].o);
                chk("zero", zero, q[0].z);
            end
        end
    endtask

    task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sb, input logic ci,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        in1 = a; in2 = b; sub = sb; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        step();
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, c_out, ec);
        chk({tag, "_ovf"}, ovf, eo & FL);
        chk({tag, "_zero"}, zero, ez & FL);
        step();
    endtask

    logic [31:0] va [4];
    logic [31:0] vb [4];

    initial begin
        int idx;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in1 = 32'h1234; in2 = 32'h1; sub = 1'b0; c_in = 1'b0;
        x_in_valid = 1'b0; x_in1 = '0; x_in2 = '0;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        chk("rst_x_out_valid", x_out_valid, 0);

        one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        one("sub57", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        one("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        one("cin", 32'h0000_FFFF, 32'h0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        one("subeq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

        va = '{32'h1111_1111, 32'hFFFF_0000, 32'h8000_0000, 32'h0000_00FF};
        vb = '{32'h2222_2222, 32'h0001_0000, 32'h0000_0001, 32'h0000_0100};
        idx = 0;
        popped = 0;
        sub = 1'b0; c_in = 1'b0;
        for (int cy = 1; cy <= 20 && (idx < 4 || q.size() > 0); cy++) begin
            out_ready = !(cy >= 3 && cy <= 5);
            in_valid = idx < 4;
            if (idx < 4) begin
                in1 = va[idx];
                in2 = vb[idx];
                sub = idx[0];
            end
            step();
            if (last_acc) idx++;
        end
        chk("b2b_sent", idx, 4);
        chk("b2b_popped", popped, 4);

        for (int i = 0; i < 40; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in1 = $urandom; in2 = $urandom; sub = $urandom % 2; c_in = $urandom % 2;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", q.size(), 0);

        in_valid = 1'b1; in1 = 32'hDEAD_0000; in2 = 32'h0000_BEEF; sub = 1'b0;
        step();
        in1 = 32'h0000_0001;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (4) step();

        x_in1 = 64'h0000_0000_FFFF_FFFF; x_in2 = 64'h1;
        for (int k = 1; k <= 8; k++) begin
            x_in_valid = (k == 1);
            if (k == 1) chk("x_in_ready", x_in_ready, 1);
            step();
            chk("x_lat", x_out_valid, k == 8);
        end
        x_in_valid = 1'b0;
        chk("x_sum", x_sum, 64'h0000_0001_0000_0000);
        chk("x_c_out", x_c_out, 0);
        chk("x_ovf", x_ovf, 0);
        chk("x_zero", x_zero, 0);
        step();
        chk("x_gone", x_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
